// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU mantissa multiplier: FSM state type, default
// mantissa width and product-width derivation.
package fpu_pkg;

  localparam int unsigned MANT_W_DEFAULT = 11;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } mul_state_e;

  function automatic int unsigned prod_width(input int unsigned mant_w);
    return 2 * mant_w;
  endfunction

endpackage

// File: rtl/fpu_mant_round.sv
// Normalises a full mantissa product to MANT_W bits with round-to-nearest-even.
// Instantiated by fpu_mant_mul_seq only when FPU_MANT_MUL_ROUND_EN is defined.
module fpu_mant_round
  import fpu_pkg::*;
#(
  parameter int unsigned MANT_W = MANT_W_DEFAULT
) (
  input  logic [prod_width(MANT_W)-1:0] prod,
  input  logic                          valid,
  output logic [MANT_W-1:0]             rnd_mant,
  output logic                          norm_shift,
  output logic                          inexact
);

  localparam int unsigned PROD_W = prod_width(MANT_W);

  logic              top;
  logic [MANT_W-1:0] kept;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [MANT_W:0]   sum;

  always_comb begin
    top = prod[PROD_W-1];
    if (top) begin
      kept   = prod[PROD_W-1:MANT_W];
      guard  = prod[MANT_W-1];
      sticky = |prod[MANT_W-2:0];
    end else begin
      kept   = prod[PROD_W-2:MANT_W-1];
      guard  = prod[MANT_W-2];
      sticky = |prod[MANT_W-3:0];
    end
    round_up = guard & (sticky | kept[0]);
    sum      = {1'b0, kept} + {{MANT_W{1'b0}}, round_up};

    rnd_mant   = '0;
    norm_shift = 1'b0;
    inexact    = 1'b0;
    if (valid) begin
      inexact = guard | sticky;
      // An all-ones mantissa rounding up renormalises to 1.000...
      if (sum[MANT_W]) begin
        rnd_mant   = {1'b1, {(MANT_W-1){1'b0}}};
        norm_shift = 1'b1;
      end else begin
        rnd_mant   = sum[MANT_W-1:0];
        norm_shift = top;
      end
    end
  end

endmodule

// File: rtl/fpu_mant_mul_seq.sv
// Sequential radix-2 shift-add mantissa multiplier, one multiplier bit per cycle.
// Define FPU_MANT_MUL_ROUND_EN to add the rounded-mantissa outputs.
module fpu_mant_mul_seq
  import fpu_pkg::*;
#(
  parameter int unsigned MANT_W = MANT_W_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [MANT_W-1:0]             a_mant,
  input  logic [MANT_W-1:0]             b_mant,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [prod_width(MANT_W)-1:0] prod,
  output logic                          busy
`ifdef FPU_MANT_MUL_ROUND_EN
  ,
  output logic [MANT_W-1:0]             rnd_mant,
  output logic                          norm_shift,
  output logic                          inexact
`endif
);

  localparam int unsigned PROD_W = prod_width(MANT_W);
  localparam int unsigned CNT_W  = $clog2(MANT_W);
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(MANT_W - 1);

  mul_state_e        state_q, state_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [MANT_W-1:0] mplier_q, mplier_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = {{MANT_W{1'b0}}, a_mant};
          mplier_d = b_mant;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StMul;
        end
      end
      StMul: begin
        // Multiplicand walks left while multiplier bits are consumed from the LSB.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LastBit) begin
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    busy      = (state_q == StMul);
    out_valid = (state_q == StDone);
    prod      = out_valid ? acc_q : '0;
  end

`ifdef FPU_MANT_MUL_ROUND_EN
  fpu_mant_round #(
    .MANT_W(MANT_W)
  ) u_round (
    .prod      (prod),
    .valid     (out_valid),
    .rnd_mant  (rnd_mant),
    .norm_shift(norm_shift),
    .inexact   (inexact)
  );
`endif

endmodule

// File: tb/tb_fpu_mant_mul_seq.sv
// Self-checking bench for fpu_mant_mul_seq: transaction-level model checked every
// cycle plus directed vectors with literal expectations.
module tb_fpu_mant_mul_seq;

  localparam int unsigned W = 11;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a_mant;
  logic [W-1:0]   b_mant;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] prod;
  logic           busy;
`ifdef FPU_MANT_MUL_ROUND_EN
  logic [W-1:0]   rnd_mant;
  logic           norm_shift;
  logic           inexact;
`endif

  fpu_mant_mul_seq #(
    .MANT_W(W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
`ifdef FPU_MANT_MUL_ROUND_EN
    ,
    .rnd_mant  (rnd_mant),
    .norm_shift(norm_shift),
    .inexact   (inexact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one op in flight, result due W edges after acceptance.
  int             cyc = 0;
  int             acc_cyc = 0;
  bit             model_live = 1'b0;
  bit             pending = 1'b0;
  logic [2*W-1:0] exp_prod = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      model_live <= 1'b1;
      pending    <= 1'b0;
    end else if (model_live) begin
      if (!pending && in_valid) begin
        pending  <= 1'b1;
        acc_cyc  <= cyc + 1;
        exp_prod <= (2*W)'(a_mant) * (2*W)'(b_mant);
      end else if (pending && (cyc - acc_cyc >= int'(W)) && out_ready) begin
        pending <= 1'b0;
      end
    end
  end

  // Rounding reference via integer arithmetic on the remainder below the kept bits.
  function automatic logic [W+1:0] round_model(input logic [63:0] p);
    int unsigned sh;
    logic [63:0] kept, rem, half;
    logic        up, nrm;
    nrm  = (p >= (64'd1 << (2*W-1)));
    sh   = nrm ? W : W - 1;
    kept = p >> sh;
    rem  = p - (kept << sh);
    half = 64'd1 << (sh - 1);
    up   = (rem > half) || ((rem == half) && kept[0]);
    kept = kept + 64'(up);
    if (kept == (64'd1 << W)) begin
      kept = 64'd1 << (W - 1);
      nrm  = 1'b1;
    end
    return {nrm, (rem != 0), kept[W-1:0]};
  endfunction

  always @(negedge clk) begin
    if (model_live) begin
      automatic bit exp_ov = pending && (cyc - acc_cyc >= int'(W));
      check("in_ready", in_ready, !pending);
      check("busy", busy, pending && !exp_ov);
      check("out_valid", out_valid, exp_ov);
      check("prod", prod, exp_ov ? exp_prod : '0);
`ifdef FPU_MANT_MUL_ROUND_EN
      begin
        automatic logic [W+1:0] r = exp_ov ? round_model(64'(exp_prod)) : '0;
        check("norm_shift", norm_shift, r[W+1]);
        check("inexact", inexact, r[W]);
        check("rnd_mant", rnd_mant, r[W-1:0]);
      end
`endif
    end
  end

  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1;
    a_mant   = a;
    b_mant   = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a_mant   = W'($urandom);
    b_mant   = W'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
      if (lat > 4 * int'(W)) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_valid_timeout: got no out_valid, expected within %0d edges", W);
        break;
      end
    end
  endtask

  task automatic finish_op(input int hold);
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input string name);
    int lat;
    start(a, b);
    wait_done(lat);
    check({name, "_latency"}, lat, W);
    check({name, "_prod"}, prod, exp);
  endtask

  initial begin
    int lat;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_mant    = '0;
    b_mant    = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_prod", prod, 0);

    out_ready = 1'b1;
    run_op(11'h0F0, 11'h70F, 22'h069E10, "basic");
    @(posedge clk);
    #1 out_ready = 1'b0;

    run_op(11'h7FF, 11'h7FF, 22'h3FF001, "max");
`ifdef FPU_MANT_MUL_ROUND_EN
    check("max_norm_shift", norm_shift, 1);
    check("max_rnd_mant", rnd_mant, 11'h7FE);
    check("max_inexact", inexact, 1);
`endif
    finish_op(1);

    run_op(11'h400, 11'h400, 22'h100000, "pow2");
`ifdef FPU_MANT_MUL_ROUND_EN
    check("pow2_norm_shift", norm_shift, 0);
    check("pow2_rnd_mant", rnd_mant, 11'h400);
    check("pow2_inexact", inexact, 0);
`endif
    finish_op(0);

    run_op(11'h000, 11'h5A5, 22'h0, "zero");
    finish_op(2);
    run_op(11'h555, 11'h2AA, 22'h0E3472, "alt");
    finish_op(0);
    run_op(11'h7FF, 11'h001, 22'h0007FF, "one");
    finish_op(0);

    // Stall in DONE while a new request is already offered.
    start(11'h123, 11'h456);
    wait_done(lat);
    check("stall_latency", lat, W);
    in_valid = 1'b1;
    a_mant   = 11'h0AB;
    b_mant   = 11'h0CD;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_prod", prod, 22'h04EDC2);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("stall_resume_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(lat);
    check("stall_next_latency", lat, W);
    check("stall_next_prod", prod, 22'h0088EF);
    finish_op(0);

    // Reset in the middle of a multiply.
    start(11'h3A5, 11'h1C3);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_prod", prod, 0);
    run_op(11'h3A5, 11'h1C3, 22'h066BAF, "postrst");
    finish_op(0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
